// File: rtl/seg7_scan_ctrl.sv
// Four-digit BCD scan controller driving one shared seven-segment decoder and active-low anodes.
// Outputs are registered with no combinational path from inputs; loads never stall and commit at the next frame boundary.
module seg7_scan_ctrl #(
  parameter int SLOT_CYC  = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [15:0] iVALUE,
  input  logic        iLOAD,
  input  logic        iBLANK_LZ,
  output logic        oBUSY,
  output logic [3:0]  oBCD,
  output logic [3:0]  oAN
);

  localparam int CW = $clog2(SLOT_CYC);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST  = cnt_t'(SLOT_CYC - 1);
  localparam cnt_t CNT_GUARD = cnt_t'(GUARD_CYC);

  cnt_t        cnt, cnt_nx;
  logic [1:0]  idx, idx_nx;
  logic [15:0] disp, disp_nx, pend;
  logic        wrap, frame_end, dig_blank;

  // Digit d is a leading zero when it and every more significant nibble are zero.
  function automatic logic lz_blank(input logic [1:0] d, input logic [15:0] v);
    logic z;
    z = 1'b1;
    for (int n = 0; n < 4; n++)
      if (n >= int'(d) && v[4*n +: 4] != 4'h0) z = 1'b0;
    return (d != 2'd0) && z;
  endfunction

  always_comb begin
    wrap      = (cnt == CNT_LAST);
    cnt_nx    = wrap ? '0 : cnt + cnt_t'(1);
    idx_nx    = wrap ? idx + 2'd1 : idx;
    frame_end = wrap && (idx == 2'd3);
    disp_nx   = disp;
    if (frame_end) begin
      if (iLOAD)      disp_nx = iVALUE;
      else if (oBUSY) disp_nx = pend;
    end
    dig_blank = iBLANK_LZ && lz_blank(idx_nx, disp_nx);
  end

  // Outputs are computed from next-state values so they move on the same edge as cnt/idx.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt   <= '0;
      idx   <= 2'd0;
      disp  <= 16'h0000;
      pend  <= 16'h0000;
      oBUSY <= 1'b0;
      oBCD  <= 4'h0;
      oAN   <= 4'b1111;
    end else begin
      cnt  <= cnt_nx;
      idx  <= idx_nx;
      disp <= disp_nx;
      if (frame_end) begin
        oBUSY <= 1'b0;
      end else if (iLOAD) begin
        pend  <= iVALUE;
        oBUSY <= 1'b1;
      end
      if (wrap)
        oBCD <= disp_nx[{idx_nx, 2'b00} +: 4];
      if (cnt_nx < CNT_GUARD || dig_blank)
        oAN <= 4'b1111;
      else
        oAN <= ~(4'b0001 << idx_nx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl with SLOT_CYC=8, GUARD_CYC=2.
module tb_seg7_scan_ctrl;
  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * SLOT;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [15:0] iVALUE = 16'h0;
  logic        iLOAD = 1'b0;
  logic        iBLANK_LZ = 1'b0;
  logic        oBUSY;
  logic [3:0]  oBCD;
  logic [3:0]  oAN;

  seg7_scan_ctrl #(.SLOT_CYC(SLOT), .GUARD_CYC(GUARD)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iVALUE(iVALUE), .iLOAD(iLOAD),
    .iBLANK_LZ(iBLANK_LZ), .oBUSY(oBUSY), .oBCD(oBCD), .oAN(oAN)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: k counts edges since reset release; slot/phase follow by arithmetic.
  int          k;
  logic [15:0] m_disp, m_pend;
  logic        m_busy, m_blz;

  function automatic void model_reset();
    k = 0; m_disp = 16'h0; m_pend = 16'h0; m_busy = 1'b0; m_blz = 1'b0;
  endfunction

  function automatic logic [3:0] exp_an();
    int c, s;
    logic [3:0] r;
    c = k % SLOT;
    s = (k / SLOT) % 4;
    if (c < GUARD) return 4'b1111;
    if (m_blz && s > 0 && (m_disp >> (4 * s)) == 16'h0) return 4'b1111;
    r = 4'b0001 << s;
    return ~r;
  endfunction

  function automatic logic [3:0] exp_bcd();
    logic [15:0] t;
    t = m_disp >> (4 * ((k / SLOT) % 4));
    return t[3:0];
  endfunction

  task automatic step(input logic ld, input logic [15:0] val);
    iLOAD = ld; iVALUE = val;
    @(posedge iCLK);
    if (k % FRAME == FRAME - 1) begin
      if (ld) m_disp = val;
      else if (m_busy) m_disp = m_pend;
      m_busy = 1'b0;
    end else if (ld) begin
      m_pend = val; m_busy = 1'b1;
    end
    m_blz = iBLANK_LZ;
    k++;
    #1;
    iLOAD = 1'b0;
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) step(1'b0, 16'h0);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    n_chk++;
    if (oAN !== 4'b1111 || oBCD !== 4'h0 || oBUSY !== 1'b0)
      $display("FAIL reset_hold an=%b bcd=%h busy=%b want 1111/0/0", oAN, oBCD, oBUSY);
    else n_pass++;
    model_reset();
    iRST_N = 1'b1;
    n_chk++;
    if (oAN !== 4'b1111)
      $display("FAIL reset_release an=%b want 1111", oAN);
    else n_pass++;
    repeat (2 * FRAME) begin
      step(1'b0, 16'h0);
      n_chk++;
      if (oAN !== exp_an() || oBCD !== exp_bcd() || oBUSY !== m_busy)
        $display("FAIL scan k=%0d an=%b want %b bcd=%h want %h busy=%b want %b",
                 k, oAN, exp_an(), oBCD, exp_bcd(), oBUSY, m_busy);
      else n_pass++;
    end
  endtask

  task automatic test_mid_load();
    run_to(9);
    step(1'b1, 16'h1234);
    n_chk++;
    if (oBUSY !== 1'b1) $display("FAIL mid_busy_rise busy=%b want 1", oBUSY);
    else n_pass++;
    while (k % FRAME != FRAME - 1) begin
      step(1'b0, 16'h0);
      n_chk++;
      if (oAN !== exp_an() || oBCD !== exp_bcd() || oBUSY !== m_busy)
        $display("FAIL mid_scan k=%0d an=%b want %b bcd=%h want %h busy=%b want %b",
                 k, oAN, exp_an(), oBCD, exp_bcd(), oBUSY, m_busy);
      else n_pass++;
    end
    step(1'b0, 16'h0);
    n_chk++;
    if (oBUSY !== 1'b0) $display("FAIL mid_busy_fall busy=%b want 0", oBUSY);
    else n_pass++;
    run_to(2);
    n_chk++;
    if (oAN !== 4'b1110 || oBCD !== 4'h4) $display("FAIL mid_digit0 an=%b bcd=%h want 1110/4", oAN, oBCD);
    else n_pass++;
    run_to(26);
    n_chk++;
    if (oAN !== 4'b0111 || oBCD !== 4'h1) $display("FAIL mid_digit3 an=%b bcd=%h want 0111/1", oAN, oBCD);
    else n_pass++;
  endtask

  task automatic test_blank();
    logic [15:0] vals [3];
    vals[0] = 16'h0045; vals[1] = 16'h0000; vals[2] = 16'h0405;
    iBLANK_LZ = 1'b1;
    for (int v = 0; v < 3; v++) begin
      run_to(9);
      step(1'b1, vals[v]);
      run_to(0);
      repeat (FRAME) begin
        step(1'b0, 16'h0);
        n_chk++;
        if (oAN !== exp_an() || oBCD !== exp_bcd() || oBUSY !== m_busy)
          $display("FAIL blank v=%h k=%0d an=%b want %b bcd=%h want %h", vals[v], k, oAN, exp_an(), oBCD, exp_bcd());
        else n_pass++;
      end
    end
    // last value 0x0405: digit 1 lit showing 0, digit 3 blanked
    run_to(10);
    n_chk++;
    if (oAN !== 4'b1101 || oBCD !== 4'h0) $display("FAIL blank_inner_zero an=%b bcd=%h want 1101/0", oAN, oBCD);
    else n_pass++;
    run_to(26);
    n_chk++;
    if (oAN !== 4'b1111) $display("FAIL blank_lead an=%b want 1111", oAN);
    else n_pass++;
    iBLANK_LZ = 1'b0;
  endtask

  task automatic test_overwrite();
    run_to(4);
    step(1'b1, 16'h1111);
    run_to(20);
    step(1'b1, 16'h2222);
    run_to(0);
    repeat (FRAME) begin
      step(1'b0, 16'h0);
      n_chk++;
      if (oAN !== exp_an() || oBCD !== exp_bcd() || oBUSY !== m_busy || (oAN != 4'b1111 && oBCD !== 4'h2))
        $display("FAIL overwrite k=%0d an=%b want %b bcd=%h want 2", k, oAN, exp_an(), oBCD);
      else n_pass++;
    end
  endtask

  task automatic test_boundary_load();
    run_to(FRAME - 1);
    step(1'b1, 16'h9876);
    n_chk++;
    if (oBUSY !== 1'b0 || oBCD !== 4'h6) $display("FAIL boundary_load busy=%b bcd=%h want 0/6", oBUSY, oBCD);
    else n_pass++;
    run_to(2);
    n_chk++;
    if (oAN !== 4'b1110 || oBCD !== 4'h6) $display("FAIL boundary_lit an=%b bcd=%h want 1110/6", oAN, oBCD);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        ld;
    logic [15:0] val;
    repeat (20 * FRAME) begin
      if ($urandom_range(0, 40) == 0) iBLANK_LZ = ~iBLANK_LZ;
      ld  = ($urandom_range(0, 15) == 0);
      val = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step(ld, val);
      n_chk++;
      if (oAN !== exp_an() || oBCD !== exp_bcd() || oBUSY !== m_busy)
        $display("FAIL random k=%0d an=%b want %b bcd=%h want %h busy=%b want %b",
                 k, oAN, exp_an(), oBCD, exp_bcd(), oBUSY, m_busy);
      else n_pass++;
    end
    iBLANK_LZ = 1'b0;
  endtask

  task automatic test_async_reset();
    run_to(10);
    step(1'b1, 16'hABCD);
    step(1'b0, 16'h0);
    n_chk++;
    if (oAN !== 4'b1101 || oBUSY !== 1'b1) $display("FAIL areset_pre an=%b busy=%b want 1101/1", oAN, oBUSY);
    else n_pass++;
    #2;
    iRST_N = 1'b0;
    #1;
    n_chk++;
    if (oAN !== 4'b1111 || oBUSY !== 1'b0 || oBCD !== 4'h0)
      $display("FAIL areset_immediate an=%b busy=%b bcd=%h want 1111/0/0", oAN, oBUSY, oBCD);
    else n_pass++;
    @(posedge iCLK);
    #1;
    model_reset();
    iRST_N = 1'b1;
    repeat (2 * FRAME) begin
      step(1'b0, 16'h0);
      n_chk++;
      if (oAN !== exp_an() || oBCD !== 4'h0 || oBUSY !== 1'b0)
        $display("FAIL areset_after k=%0d an=%b want %b bcd=%h want 0 busy=%b want 0", k, oAN, exp_an(), oBCD, oBUSY);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mid_load();
    test_blank();
    test_overwrite();
    test_boundary_load();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
